logo_anim_sequencer: RTL and testbench

LOGO_ANIM_SEQUENCER -- requirements
Module: logo_anim_sequencer

---
 rtl/logo_anim_pkg.sv | 27 ++
 rtl/logo_anim_sequencer_bounce_axis.sv | 57 +++++
 rtl/logo_anim_sequencer.sv | 153 +++++++++++++++
 tb/tb_logo_anim_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logo_anim_pkg.sv
// Shared definitions for the logo animation sequencer: state encoding,
// logo base colour, full-brightness fade level and the fade colour helper.
package logo_anim_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FADE_IN  = 3'd1,
    HOLD     = 3'd2,
    BOUNCE   = 3'd3,
    FADE_OUT = 3'd4
  } anim_state_e;

  localparam logic [5:0] LOGO_BASE = 6'b111101;
  localparam logic [3:0] FADE_MAX  = 4'd8;

  // Scale each 2-bit channel of the base colour by fade/8.
  function automatic logic [5:0] fade_rgb(input logic [3:0] f);
    logic [5:0] p_r;
    logic [5:0] p_g;
    logic [5:0] p_b;
    p_r = {4'b0, LOGO_BASE[5:4]} * {2'b0, f};
    p_g = {4'b0, LOGO_BASE[3:2]} * {2'b0, f};
    p_b = {4'b0, LOGO_BASE[1:0]} * {2'b0, f};
    return {2'(p_r >> 3), 2'(p_g >> 3), 2'(p_b >> 3)};
  endfunction

endpackage

// File: rtl/logo_anim_sequencer_bounce_axis.sv
// One bounce axis: signed position with direction, reflecting at +/-LIM.
module anim_bounce_axis #(
  parameter int LIM = 80
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              clr,
  input  logic [2:0]        step,
  output logic signed [8:0] pos
);

  localparam logic signed [9:0] LIM_P = 10'(LIM);
  localparam logic signed [9:0] LIM_N = -LIM_P;

  logic signed [8:0] pos_q, pos_d;
  logic              dir_q, dir_d;
  logic signed [9:0] sum;

  // Next position: 10-bit sum so the reflection compare never sees a wrap.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (dir_q)
      sum = $signed({pos_q[8], pos_q}) - $signed({7'b0, step});
    else
      sum = $signed({pos_q[8], pos_q}) + $signed({7'b0, step});
    if (clr) begin
      pos_d = '0;
      dir_d = 1'b0;
    end else if (adv) begin
      if (sum >= LIM_P) begin
        pos_d = LIM_P[8:0];
        dir_d = 1'b1;
      end else if (sum <= LIM_N) begin
        pos_d = LIM_N[8:0];
        dir_d = 1'b0;
      end else begin
        pos_d = sum[8:0];
      end
    end
  end

  // Position and direction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
      dir_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/logo_anim_sequencer.sv
// Logo animation sequencer: fade in, hold, bounce, fade out, advancing once
// per frame at the start of vertical blanking, with pause and single-step.
module logo_anim_sequencer
  import logo_anim_pkg::*;
#(
  parameter int V_ACTIVE      = 480,
  parameter int X_LIM         = 80,
  parameter int Y_LIM         = 16,
  parameter int HOLD_FRAMES   = 60,
  parameter int BOUNCE_FRAMES = 600
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        hpos,
  input  logic [9:0]        vpos,
  input  logic              run,
  input  logic              pause,
  input  logic              step,
  input  logic [1:0]        speed,
  output logic signed [8:0] x_off,
  output logic signed [8:0] y_off,
  output logic [3:0]        fade,
  output logic [5:0]        logo_rgb,
  output logic [10:0]       frame,
  output logic [2:0]        state
);

  anim_state_e state_q, state_d;
  logic [3:0]  fade_q, fade_d, fade_dec;
  logic [9:0]  cnt_q, cnt_d;
  logic [10:0] frame_q, frame_d;
  logic [5:0]  logo_rgb_q, logo_rgb_d;
  logic        step_pending_q, step_pending_d;
  logic        tick, adv, bounce_adv, axis_clr;
  logic [2:0]  step_size;

  assign tick      = (vpos == 10'(V_ACTIVE)) && (hpos == 10'd0);
  // A step arriving on the tick cycle itself is folded into that advance.
  assign adv       = tick && (!pause || step_pending_q || step);
  assign step_size = {1'b0, speed} + 3'd1;

  // Frame counter, step latch and faded colour.
  always_comb begin
    frame_d        = tick ? frame_q + 11'd1 : frame_q;
    step_pending_d = tick ? 1'b0 : (step ? 1'b1 : step_pending_q);
    logo_rgb_d     = fade_rgb(fade_d);
  end

  // Next-state logic; dropping run in an active phase wins over everything.
  always_comb begin
    state_d    = state_q;
    fade_d     = fade_q;
    cnt_d      = cnt_q;
    bounce_adv = 1'b0;
    axis_clr   = 1'b0;
    fade_dec   = (fade_q == 4'd0) ? 4'd0 : fade_q - 4'd1;
    if (adv) begin
      if (!run && (state_q == FADE_IN || state_q == HOLD || state_q == BOUNCE)) begin
        state_d = FADE_OUT;
        fade_d  = fade_dec;
        cnt_d   = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (run) state_d = FADE_IN;
          end
          FADE_IN: begin
            fade_d = fade_q + 4'd1;
            if (fade_q == FADE_MAX - 4'd1) begin
              state_d = HOLD;
              cnt_d   = '0;
            end
          end
          HOLD: begin
            if (cnt_q == 10'(HOLD_FRAMES - 1)) begin
              state_d = BOUNCE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 10'd1;
            end
          end
          BOUNCE: begin
            bounce_adv = 1'b1;
            if (cnt_q == 10'(BOUNCE_FRAMES - 1)) begin
              state_d = FADE_OUT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 10'd1;
            end
          end
          FADE_OUT: begin
            if (fade_q <= 4'd1) begin
              fade_d = 4'd0;
              if (run) begin
                state_d = FADE_IN;
              end else begin
                state_d  = IDLE;
                axis_clr = 1'b1;
                cnt_d    = '0;
              end
            end else begin
              fade_d = fade_dec;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      fade_q         <= '0;
      cnt_q          <= '0;
      frame_q        <= '0;
      logo_rgb_q     <= '0;
      step_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fade_q         <= fade_d;
      cnt_q          <= cnt_d;
      frame_q        <= frame_d;
      logo_rgb_q     <= logo_rgb_d;
      step_pending_q <= step_pending_d;
    end
  end

  anim_bounce_axis #(.LIM(X_LIM)) u_axis_x (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (bounce_adv),
    .clr   (axis_clr),
    .step  (step_size),
    .pos   (x_off)
  );

  anim_bounce_axis #(.LIM(Y_LIM)) u_axis_y (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (bounce_adv),
    .clr   (axis_clr),
    .step  (step_size),
    .pos   (y_off)
  );

  assign fade     = fade_q;
  assign logo_rgb = logo_rgb_q;
  assign frame    = frame_q;
  assign state    = state_q;

endmodule

// File: tb/tb_logo_anim_sequencer.sv
// Bench for logo_anim_sequencer: directed phases plus randomized frames,
// all compared against a frame-level behavioural model.
module tb_logo_anim_sequencer;

  localparam int V_ACT    = 480;
  localparam int XL       = 80;
  localparam int YL       = 16;
  localparam int HOLD_N   = 60;
  localparam int BOUNCE_N = 600;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [9:0]        hpos, vpos;
  logic              run, pause, step;
  logic [1:0]        speed;
  logic signed [8:0] x_off, y_off;
  logic [3:0]        fade;
  logic [5:0]        logo_rgb;
  logic [10:0]       frame;
  logic [2:0]        state;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: phase number, brightness, frame counts, positions.
  int  m_state, m_fade, m_cnt, m_frame, m_x, m_y, m_dx, m_dy;
  bit  m_pend;

  logo_anim_sequencer #(
    .V_ACTIVE(V_ACT), .X_LIM(XL), .Y_LIM(YL),
    .HOLD_FRAMES(HOLD_N), .BOUNCE_FRAMES(BOUNCE_N)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos),
    .run(run), .pause(pause), .step(step), .speed(speed),
    .x_off(x_off), .y_off(y_off), .fade(fade), .logo_rgb(logo_rgb),
    .frame(frame), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_rgb(input int f);
    int r, g, b;
    r = (3 * f) / 8;
    g = (3 * f) / 8;
    b = (1 * f) / 8;
    return r * 16 + g * 4 + b;
  endfunction

  task automatic model_reset();
    m_state = 0; m_fade = 0; m_cnt = 0; m_frame = 0;
    m_x = 0; m_y = 0; m_dx = 1; m_dy = 1; m_pend = 0;
  endtask

  task automatic move(inout int p, inout int d, input int lim);
    p = p + d * (int'(speed) + 1);
    if (p >= lim) begin
      p = lim; d = -1;
    end else if (p <= -lim) begin
      p = -lim; d = 1;
    end
  endtask

  task automatic model_frame();
    if (m_state >= 1 && m_state <= 3 && !run) begin
      m_state = 4;
      m_fade  = (m_fade > 0) ? m_fade - 1 : 0;
      return;
    end
    case (m_state)
      0: if (run) m_state = 1;
      1: begin
        m_fade++;
        if (m_fade == 8) begin m_state = 2; m_cnt = 0; end
      end
      2: begin
        if (m_cnt == HOLD_N - 1) begin m_state = 3; m_cnt = 0; end
        else m_cnt++;
      end
      3: begin
        move(m_x, m_dx, XL);
        move(m_y, m_dy, YL);
        if (m_cnt == BOUNCE_N - 1) begin m_state = 4; m_cnt = 0; end
        else m_cnt++;
      end
      default: begin
        if (m_fade <= 1) begin
          m_fade = 0;
          if (run) m_state = 1;
          else begin
            m_state = 0; m_cnt = 0;
            m_x = 0; m_y = 0; m_dx = 1; m_dy = 1;
          end
        end else m_fade--;
      end
    endcase
  endtask

  task automatic model_edge(input bit t, input bit s);
    if (t) begin
      m_frame = (m_frame + 1) % 2048;
      if (!pause || m_pend || s) model_frame();
      m_pend = 0;
    end else if (s) begin
      m_pend = 1;
    end
  endtask

  task automatic check_all();
    check("state", int'(state), m_state);
    check("fade", int'(fade), m_fade);
    check("x_off", int'(x_off), m_x);
    check("y_off", int'(y_off), m_y);
    check("logo_rgb", int'(logo_rgb), exp_rgb(m_fade));
    check("frame", int'(frame), m_frame);
  endtask

  // One clock: drive raster position (tick or a near-miss) and step.
  task automatic cycle(input bit t, input bit s);
    @(negedge clk);
    if (t) begin
      vpos = 10'(V_ACT); hpos = 10'd0;
    end else if ($urandom_range(0, 1) == 1) begin
      vpos = 10'(V_ACT); hpos = 10'($urandom_range(1, 799));
    end else begin
      vpos = 10'($urandom_range(0, 479)); hpos = 10'd0;
    end
    step = s;
    @(posedge clk);
    model_edge(t, s);
    #1;
    step = 1'b0;
    check_all();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b0);
      repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_fade"}, int'(fade), 0);
    check({tag, "_x"}, int'(x_off), 0);
    check({tag, "_y"}, int'(y_off), 0);
    check({tag, "_rgb"}, int'(logo_rgb), 0);
    check({tag, "_frame"}, int'(frame), 0);
  endtask

  int saved_x, saved_frame;

  initial begin
    rst_n = 1'b0; hpos = '0; vpos = '0;
    run = 1'b0; pause = 1'b0; step = 1'b0; speed = 2'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;

    // Non-tick cycles right after reset change nothing.
    run = 1'b1; speed = 2'd3;
    repeat (4) cycle(1'b0, 1'b0);

    // Fade in over 9 frames, then hold.
    tick_n(1);
    check("fadein_entry", int'(state), 1);
    tick_n(8);
    check("hold_after_9", int'(state), 2);
    check("rgb_full", int'(logo_rgb), 6'b111101);
    tick_n(HOLD_N);
    check("bounce_entry", int'(state), 3);

    // Bounce at 4 px/frame: x reaches 80 then reflects to 72.
    tick_n(22);
    check("x_reflect", int'(x_off), 72);

    // Paused frames freeze the offsets but not the frame counter.
    pause = 1'b1;
    saved_x = int'(x_off);
    saved_frame = int'(frame);
    tick_n(5);
    check("pause_x", int'(x_off), saved_x);
    check("pause_frame", int'(frame), (saved_frame + 5) % 2048);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    tick_n(1);
    check("step_move", int'(x_off), saved_x - 4);
    cycle(1'b1, 1'b1);
    check("step_same_cycle", int'(x_off), saved_x - 8);
    tick_n(1);
    check("step_cleared", int'(x_off), saved_x - 8);
    pause = 1'b0;

    // Run dropped mid-bounce: fade out to IDLE, offsets cleared.
    run = 1'b0;
    tick_n(8);
    check("drop_idle", int'(state), 0);
    check("drop_x0", int'(x_off), 0);

    // Run dropped in HOLD.
    run = 1'b1;
    tick_n(12);
    check("in_hold", int'(state), 2);
    run = 1'b0;
    tick_n(1);
    check("hold_drop_fadeout", int'(state), 4);
    check("hold_drop_fade", int'(fade), 7);
    tick_n(7);
    check("hold_drop_idle", int'(state), 0);
    check("hold_drop_x", int'(x_off), 0);

    // Async reset mid-bounce, between ticks.
    run = 1'b1;
    tick_n(9 + HOLD_N + 5);
    cycle(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_all();

    // Randomized frames; long enough for the frame counter to wrap.
    run = 1'b1;
    for (int i = 0; i < 2200; i++) begin
      if (i % 40 == 0) run = ($urandom_range(0, 9) != 0);
      pause = ($urandom_range(0, 6) == 0);
      speed = 2'($urandom_range(0, 3));
      cycle(1'b1, ($urandom_range(0, 9) == 0));
      repeat ($urandom_range(0, 2)) cycle(1'b0, ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
